// File: rtl/normalizer_loader.sv
// DMA reader that streams packed 16-bit sample pairs through a 2-entry prefetch FIFO.
// Optional running min/max of pushed samples: define NORMALIZER_LOADER_MINMAX_EN.
module normalizer_loader #(
  parameter int ROW_WORDS = 128,
  parameter int ROW_SKIP  = 128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] start_addr,
  input  logic [31:0] stop_addr,
  input  logic        start,
  input  logic        stride_en,
  output logic [31:0] dma_addr,
  output logic        dma_read,
  input  logic [31:0] dma_readdata,
  input  logic        dma_rdy,
  output logic [15:0] spect_data_1,
  output logic [15:0] spect_data_2,
  output logic        spect_valid,
  input  logic        spect_rdy,
  output logic        busy,
  output logic        irq,
  output logic [15:0] max,
  output logic [15:0] min
);
  // Stream handshake: a pair moves when spect_valid & spect_rdy at a clock edge;
  // the head is held stable while spect_valid=1 and spect_rdy=0.
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t      state;
  logic [31:0] rd_addr;
  logic [31:0] row_cnt;
  logic        outstanding;
  logic [1:0]  stale;
  logic [1:0]  fill;
  logic [31:0] head;
  logic [31:0] tail;

  logic [31:0] iss_addr;
  logic [31:0] iss_cnt;
  logic [31:0] adv_addr;
  logic [31:0] adv_cnt;
  logic        row_wrap;
  logic        is_last;
  logic        issue;
  logic        rdy_old;
  logic        rdy_cur;
  logic        pop;

  // A start issues its first read immediately, so the walk starts from start_addr.
  always_comb begin
    iss_addr = start ? start_addr : rd_addr;
    iss_cnt  = start ? 32'd0 : row_cnt;
    row_wrap = stride_en && (iss_cnt == 32'(ROW_WORDS));
    adv_addr = iss_addr + (row_wrap ? 32'(ROW_SKIP) : 32'd4);
    adv_cnt  = row_wrap ? 32'd0 : iss_cnt + 32'd1;
    is_last  = (iss_addr >= stop_addr);
    issue    = (state == RUN) && !outstanding && (fill < 2'd2);
    rdy_old  = dma_rdy && (stale != 2'd0);
    rdy_cur  = dma_rdy && (stale == 2'd0) && outstanding;
    pop      = spect_valid && spect_rdy;
  end

  assign spect_data_1 = head[31:16];
  assign spect_data_2 = head[15:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rd_addr     <= '0;
      row_cnt     <= '0;
      outstanding <= 1'b0;
      stale       <= '0;
      fill        <= '0;
      head        <= '0;
      tail        <= '0;
      dma_addr    <= '0;
      dma_read    <= 1'b0;
      spect_valid <= 1'b0;
      busy        <= 1'b0;
      irq         <= 1'b0;
    end else begin
      dma_read <= 1'b0;
      irq      <= 1'b0;
      if (start) begin
        // Completions of aborted reads still arrive in order; count them so they are discarded.
        stale       <= stale - {1'b0, rdy_old} + {1'b0, outstanding && !rdy_cur};
        fill        <= '0;
        spect_valid <= 1'b0;
        outstanding <= 1'b1;
        dma_read    <= 1'b1;
        dma_addr    <= iss_addr;
        rd_addr     <= adv_addr;
        row_cnt     <= adv_cnt;
        busy        <= 1'b1;
        state       <= is_last ? DRAIN : RUN;
      end else begin
        if (rdy_old) stale <= stale - 2'd1;
        if (rdy_cur) outstanding <= 1'b0;
        if (issue) begin
          outstanding <= 1'b1;
          dma_read    <= 1'b1;
          dma_addr    <= iss_addr;
          rd_addr     <= adv_addr;
          row_cnt     <= adv_cnt;
          if (is_last) state <= DRAIN;
        end
        case ({rdy_cur, pop})
          2'b10: begin
            if (fill == 2'd0) head <= dma_readdata;
            else tail <= dma_readdata;
            fill        <= fill + 2'd1;
            spect_valid <= 1'b1;
          end
          2'b01: begin
            head        <= tail;
            fill        <= fill - 2'd1;
            spect_valid <= (fill == 2'd2);
          end
          2'b11: begin
            if (fill == 2'd1) head <= dma_readdata;
            else begin
              head <= tail;
              tail <= dma_readdata;
            end
          end
          default: ;
        endcase
        case (state)
          DRAIN: if (fill == 2'd0 && !outstanding) begin
            state <= DONE;
            irq   <= 1'b1;
            busy  <= 1'b0;
          end
          DONE: state <= IDLE;
          default: ;
        endcase
      end
    end
  end

`ifdef NORMALIZER_LOADER_MINMAX_EN
  logic [15:0] pair_hi;
  logic [15:0] pair_lo;
  logic [15:0] pair_max;
  logic [15:0] pair_min;
  logic [15:0] max_n;
  logic [15:0] min_n;

  always_comb begin
    pair_hi  = dma_readdata[31:16];
    pair_lo  = dma_readdata[15:0];
    pair_max = (pair_hi > pair_lo) ? pair_hi : pair_lo;
    pair_min = (pair_hi < pair_lo) ? pair_hi : pair_lo;
    max_n    = (pair_max > max) ? pair_max : max;
    min_n    = (pair_min < min) ? pair_min : min;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      max <= '0;
      min <= '0;
    end else if (start) begin
      max <= 16'h0000;
      min <= 16'hFFFF;
    end else if (rdy_cur) begin
      max <= max_n;
      min <= min_n;
    end
  end
`else
  assign max = '0;
  assign min = '0;
`endif

endmodule

// File: tb/tb_normalizer_loader.sv
// Directed bench for normalizer_loader: table of transfers plus backpressure,
// stride, restart, reset and min/max sequences against an in-order memory model.
module tb_normalizer_loader;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] start_addr = '0;
  logic [31:0] stop_addr = '0;
  logic        start = 1'b0;
  logic        stride_en = 1'b0;
  logic [31:0] dma_addr;
  logic        dma_read;
  logic [31:0] dma_readdata = '0;
  logic        dma_rdy = 1'b0;
  logic [15:0] spect_data_1;
  logic [15:0] spect_data_2;
  logic        spect_valid;
  logic        spect_rdy = 1'b0;
  logic        busy;
  logic        irq;
  logic [15:0] max;
  logic [15:0] min;

  normalizer_loader dut (
    .clk(clk), .rst(rst), .start_addr(start_addr), .stop_addr(stop_addr),
    .start(start), .stride_en(stride_en), .dma_addr(dma_addr), .dma_read(dma_read),
    .dma_readdata(dma_readdata), .dma_rdy(dma_rdy), .spect_data_1(spect_data_1),
    .spect_data_2(spect_data_2), .spect_valid(spect_valid), .spect_rdy(spect_rdy),
    .busy(busy), .irq(irq), .max(max), .min(min)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] addr;
    int          cnt;
  } pend_t;

  pend_t       pend[$];
  logic [31:0] rd_log[$];
  logic [31:0] exp_q[$];
  int          rdy_cnt = 0;
  int          irq_cnt = 0;
  int          pop_cnt = 0;
  logic [15:0] irq_max = '0;
  logic [15:0] irq_min = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] data_of(input logic [31:0] a);
    case (a)
      32'h0000_0100: return 32'hAAAA5555;
      32'h0000_0800: return 32'h00100020;
      32'h0000_0804: return 32'hFFFF0001;
      default:       return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endcase
  endfunction

  // Memory answers reads in order, dma_rdy two cycles after the dma_read cycle.
  always @(negedge clk) begin
    dma_rdy = 1'b0;
    if (pend.size() > 0) begin
      if (pend[0].cnt <= 1) begin
        dma_rdy      = 1'b1;
        dma_readdata = data_of(pend[0].addr);
        void'(pend.pop_front());
        rdy_cnt++;
      end else begin
        pend[0].cnt = pend[0].cnt - 1;
      end
    end
    if (dma_read) begin
      rd_log.push_back(dma_addr);
      pend.push_back('{dma_addr, 2});
    end
    if (irq) begin
      irq_cnt++;
      irq_max = max;
      irq_min = min;
      check("busy_at_irq", {31'd0, busy}, 32'd0);
    end
    if (spect_valid && spect_rdy) begin
      pop_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL extra_pair actual=%h required=none", {spect_data_1, spect_data_2});
      end else begin
        check("pair_data", {spect_data_1, spect_data_2}, exp_q.pop_front());
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    rd_log.delete();
    exp_q.delete();
    rdy_cnt = 0;
    irq_cnt = 0;
    pop_cnt = 0;
  endtask

  task automatic pulse_start(input logic [31:0] sa, input logic [31:0] so, input logic se);
    start_addr = sa;
    stop_addr  = so;
    stride_en  = se;
    start      = 1'b1;
    tick(1);
    start      = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int c = 0;
    while (irq_cnt == 0 && c < budget) begin
      tick(1);
      c++;
    end
    if (irq_cnt == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=no_irq required=irq", tag);
    end
    tick(4);
    check({tag, "_irq_count"}, irq_cnt, 32'd1);
    check({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
  endtask

  typedef struct {
    logic [31:0] sa;
    logic [31:0] so;
    int          n;
    logic [31:0] last;
  } vec_t;

  vec_t        vecs[5];
  logic [31:0] lastv;

  initial begin
    vecs[0] = '{32'h0000_0100, 32'h0000_010C, 4, 32'h0000_010C};
    vecs[1] = '{32'h0000_0200, 32'h0000_0200, 1, 32'h0000_0200};
    vecs[2] = '{32'h0000_0300, 32'h0000_0100, 1, 32'h0000_0300};
    vecs[3] = '{32'h0000_1000, 32'h0000_1003, 2, 32'h0000_1004};
    vecs[4] = '{32'hFFFF_FFF0, 32'hFFFF_FFFC, 4, 32'hFFFF_FFFC};

    tick(3);
    rst = 1'b0;
    check("rst_dma_addr", dma_addr, 32'd0);
    check("rst_flags", {27'd0, dma_read, spect_valid, busy, irq, 1'b0}, 32'd0);
    check("rst_data", {spect_data_1, spect_data_2}, 32'd0);
    check("rst_minmax", {max, min}, 32'd0);

    spect_rdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      clear_logs();
      for (int k = 0; k < vecs[i].n; k++) exp_q.push_back(data_of(vecs[i].sa + 32'(4 * k)));
      pulse_start(vecs[i].sa, vecs[i].so, 1'b0);
      check("first_read", {31'd0, dma_read}, 32'd1);
      check("first_addr", dma_addr, vecs[i].sa);
      check("busy_run", {31'd0, busy}, 32'd1);
      wait_done(200, "table");
      check("read_count", rd_log.size(), 32'(vecs[i].n));
      lastv = (rd_log.size() > 0) ? rd_log[rd_log.size() - 1] : 32'hDEAD_BEEF;
      check("last_addr", lastv, vecs[i].last);
      check("pop_count", pop_cnt, 32'(vecs[i].n));
      check("exp_left", exp_q.size(), 32'd0);
    end

    // Backpressure: FIFO fills with two words and the head holds.
    clear_logs();
    spect_rdy = 1'b0;
    for (int k = 0; k < 8; k++) exp_q.push_back(data_of(32'h3000 + 32'(4 * k)));
    pulse_start(32'h3000, 32'h301C, 1'b0);
    tick(6);
    check("bp_head_early", {spect_data_1, spect_data_2}, data_of(32'h3000));
    tick(14);
    check("bp_rdy_count", rdy_cnt, 32'd2);
    check("bp_read_count", rd_log.size(), 32'd2);
    check("bp_valid", {31'd0, spect_valid}, 32'd1);
    check("bp_head_late", {spect_data_1, spect_data_2}, data_of(32'h3000));
    spect_rdy = 1'b1;
    wait_done(300, "bp");
    check("bp_pop_count", pop_cnt, 32'd8);
    check("bp_exp_left", exp_q.size(), 32'd0);

    // Stride: 129th read at 0x200, then +128 skip to 0x280, then +4 steps.
    clear_logs();
    for (int k = 0; k < 129; k++) exp_q.push_back(data_of(32'(4 * k)));
    for (int k = 0; k < 5; k++) exp_q.push_back(data_of(32'h280 + 32'(4 * k)));
    pulse_start(32'h0, 32'h290, 1'b1);
    wait_done(2000, "stride");
    check("stride_count", rd_log.size(), 32'd134);
    if (rd_log.size() >= 131) begin
      check("stride_r128", rd_log[127], 32'h1FC);
      check("stride_r129", rd_log[128], 32'h200);
      check("stride_r130", rd_log[129], 32'h280);
      check("stride_r131", rd_log[130], 32'h284);
    end
    check("stride_pops", pop_cnt, 32'd134);
    stride_en = 1'b0;

    // Restart while the second read is outstanding; its late completion must be dropped.
    clear_logs();
    spect_rdy = 1'b0;
    pulse_start(32'h100, 32'h13C, 1'b0);
    for (int c = 0; c < 50 && rd_log.size() < 2; c++) tick(1);
    check("rs_setup_reads", rd_log.size(), 32'd2);
    clear_logs();
    for (int k = 0; k < 3; k++) exp_q.push_back(data_of(32'h400 + 32'(4 * k)));
    pulse_start(32'h400, 32'h408, 1'b0);
    check("rs_flushed", {31'd0, spect_valid}, 32'd0);
    check("rs_read", {31'd0, dma_read}, 32'd1);
    check("rs_addr", dma_addr, 32'h400);
    spect_rdy = 1'b1;
    wait_done(200, "restart");
    check("rs_pops", pop_cnt, 32'd3);
    check("rs_exp_left", exp_q.size(), 32'd0);

    // Reset mid-transfer.
    clear_logs();
    for (int k = 0; k < 16; k++) exp_q.push_back(data_of(32'h100 + 32'(4 * k)));
    pulse_start(32'h100, 32'h13C, 1'b0);
    tick(6);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("mr_dma_addr", dma_addr, 32'd0);
    check("mr_flags", {27'd0, dma_read, spect_valid, busy, irq, 1'b0}, 32'd0);
    check("mr_data", {spect_data_1, spect_data_2}, 32'd0);
    check("mr_minmax", {max, min}, 32'd0);
    clear_logs();
    tick(15);
    check("mr_no_irq", irq_cnt, 32'd0);
    check("mr_no_read", rd_log.size(), 32'd0);
    check("mr_idle", {30'd0, busy, spect_valid}, 32'd0);

    // Min/max over words 0x00100020 and 0xFFFF0001.
    clear_logs();
    exp_q.push_back(data_of(32'h800));
    exp_q.push_back(data_of(32'h804));
    pulse_start(32'h800, 32'h804, 1'b0);
    wait_done(200, "minmax");
`ifdef NORMALIZER_LOADER_MINMAX_EN
    check("irq_max", {16'd0, irq_max}, 32'h0000_FFFF);
    check("irq_min", {16'd0, irq_min}, 32'h0000_0001);
`else
    check("irq_max", {16'd0, irq_max}, 32'd0);
    check("irq_min", {16'd0, irq_min}, 32'd0);
`endif
    check("minmax_pops", pop_cnt, 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/normalizer_loader.md
Name: normalizer_loader

Overview:
- DMA reader that fetches packed spectrum words (two 16-bit samples per 32-bit word) from memory between start_addr and stop_addr.
- Streams the sample pairs out on a valid/ready interface to the normalizer datapath.
- Mirror of the normalizer save path: same address walk, same row-stride rule, same one-shot irq on completion.
- Uses a 2-entry prefetch FIFO with at most one DMA read outstanding.

Parameters:
- ROW_WORDS, 128: words per row before a stride skip applies (when stride_en=1).
- ROW_SKIP, 128: byte increment applied at a row boundary instead of +4.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- start_addr  in  32  byte address of the first word
- stop_addr  in  32  byte address of the last word
- start  in  1  one-cycle pulse; (re)starts a transfer
- stride_en  in  1  enables the row-skip address rule
- dma_addr  out  32  read address
- dma_read  out  1  one-cycle read request
- dma_readdata  in  32  read data; valid only in a cycle with dma_rdy=1
- dma_rdy  in  1  read completion strobe
- spect_data_1  out  16  FIFO head, bits [31:16]
- spect_data_2  out  16  FIFO head, bits [15:0]
- spect_valid  out  1  FIFO head is valid
- spect_rdy  in  1  consumer accepts the head
- busy  out  1  transfer in progress
- irq  out  1  one-cycle completion pulse
- max  out  16  running max (optional feature)
- min  out  16  running min (optional feature)

Behaviour:
- Reset values: all outputs are 0. FIFO empty, state IDLE, read address 0, row counter 0.
- All outputs are registered.
- States:
  - IDLE: waits for start.
  - RUN: issues reads while address ≤ stop_addr has not yet been issued.
  - DRAIN: all reads issued; waits until the FIFO empties.
  - DONE: asserts irq for 1 cycle, then IDLE.
- start, in any state including mid-transfer:
  - flush the FIFO, drop the outstanding-read flag, rd_addr = start_addr, counter = 0, go to RUN.
  - A dma_rdy for the aborted read that arrives after start is ignored.
  - start has priority over all other same-cycle events.
- Read issue, in RUN:
  - Condition: no read outstanding, FIFO occupancy + outstanding < 2, and the last address not yet issued.
  - Action: in the next cycle, dma_read = 1 for exactly 1 cycle with dma_addr = rd_addr.
  - start to first dma_read = 1 cycle.
- Address advance (on issue):
  - If stride_en and counter == ROW_WORDS: counter = 0, rd_addr += ROW_SKIP.
  - Otherwise: counter += 1, rd_addr += 4.
  - 32-bit arithmetic, wraps modulo 2^32.
- Last word: the issued word with address ≥ stop_addr (unsigned). After it, go to DRAIN. start_addr > stop_addr therefore reads exactly one word.
- dma_rdy:
  - When a read is outstanding: push dma_readdata into the FIFO and clear the outstanding flag.
  - When no read is outstanding: ignored.
- Stream handshake:
  - spect_valid = FIFO non-empty. Head data stays stable while spect_valid=1 and spect_rdy=0.
  - A transfer occurs when spect_valid & spect_rdy.
  - Push and pop in the same cycle keep occupancy unchanged. A push into an empty FIFO presents valid on the next cycle.
- FIFO full: no new read is issued. The outstanding-read accounting above guarantees no overflow.
- Completion: in DRAIN, when the FIFO is empty and no read is outstanding, go to DONE. irq pulses 1 cycle; busy falls the same cycle.
- dma_rdy arriving in the same cycle as a pop: both are honoured.

Optional Feature:
- NORMALIZER_LOADER_MINMAX_EN defined:
  - max/min are reset to 0x0000/0xFFFF on start.
  - On every FIFO push, both 16-bit halves are compared (unsigned) and max/min are updated.
  - Values are final when irq fires.
- Not defined: max and min are tied to 0 and no comparison logic is built.

Test Plan:
- Basic read: start_addr=0x100, stop_addr=0x10C, stride_en=0, spect_rdy=1, dma_rdy 2 cycles after each read.
  - Expect reads at 0x100, 0x104, 0x108, 0x10C.
  - Expect 4 pairs out in order; data 0xAAAA5555 gives spect_data_1=0xAAAA, spect_data_2=0x5555.
  - Expect one irq pulse, busy then 0.
- Backpressure: spect_rdy=0 for 20 cycles.
  - Expect at most 2 reads completed and data held stable.
  - Release spect_rdy: no word is lost or duplicated.
- Stride: stride_en=1, ROW_WORDS=128, start_addr=0.
  - Expect the 129th read at 0x200, the 130th read at 0x280 (+128 skip), then +4 steps.
- Restart mid-transfer: pulse start during an outstanding read, with new start_addr=0x400.
  - Expect FIFO flushed and the late dma_rdy ignored.
  - Expect the next dma_read at 0x400 one cycle after start, and no irq from the aborted run.
- Reset mid-transfer: assert rst for 1 cycle.
  - Expect all outputs 0 the next cycle, no irq, and IDLE until start.
- With NORMALIZER_LOADER_MINMAX_EN: words 0x00100020 and 0xFFFF0001.
  - Expect max=0xFFFF and min=0x0001 at irq.
